// File: rtl/fifo_ctrl_pkg.sv
// Shared helpers for the FIFO family: address sizing and
// non-power-of-two-safe pointer wrap.
package fifo_ctrl_pkg;

    function automatic int CeilLog2(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

    function automatic int unsigned next_ptr(
        input int unsigned ptr,
        input int unsigned depth
    );
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ctrl_ptr.sv
// One wrap-around FIFO pointer; wraps at DEPTH-1 without
// relying on binary rollover.
module fifo_ptr
    import fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = CeilLog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    logic [AW-1:0] r_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= AW'(next_ptr(32'(r_ptr), DEPTH));
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller for a single-clock FWFT FIFO beside
// a dual-port RAM: write enable, addresses, occupancy, errors.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int MEM_DEPTH  = 4,
    parameter int ADDR_WIDTH = CeilLog2(MEM_DEPTH),
    parameter int CNT_WIDTH  = CeilLog2(MEM_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic                  full,
    output logic                  empty,
    output logic [CNT_WIDTH-1:0]  count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(MEM_DEPTH);

    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_overflow;
    logic                 r_underflow;
    logic                 w_push_ok;
    logic                 w_pop_ok;

    // Pointers are equal both when full and empty, so flags come from count.
    assign empty = (r_count == '0);
    assign full  = (r_count == FULL_CNT);

    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);
    assign we        = w_push_ok;

    fifo_ptr #(
        .DEPTH (MEM_DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_push_ok),
        .ptr   (write_addr)
    );

    fifo_ptr #(
        .DEPTH (MEM_DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_pop_ok),
        .ptr   (read_addr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_overflow  <= push & ~w_push_ok;
            r_underflow <= pop & ~w_pop_ok;
        end
    end

    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized and directed bench for fifo_ctrl at depths 4 and 5
// against a queue-based FIFO model with a behavioural RAM.
module tb_fifo_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       push0, pop0, push1, pop1;
    logic       we0, we1, full0, full1, empty0, empty1;
    logic       ovf0, ovf1, unf0, unf1;
    logic [1:0] wa0, ra0;
    logic [2:0] cnt0, wa1, ra1, cnt1;

    fifo_ctrl #(.MEM_DEPTH(4)) u_d4 (
        .clk        (clk),
        .reset      (rst_n),
        .push       (push0),
        .pop        (pop0),
        .we         (we0),
        .write_addr (wa0),
        .read_addr  (ra0),
        .full       (full0),
        .empty      (empty0),
        .count      (cnt0),
        .overflow   (ovf0),
        .underflow  (unf0)
    );

    fifo_ctrl #(.MEM_DEPTH(5)) u_d5 (
        .clk        (clk),
        .reset      (rst_n),
        .push       (push1),
        .pop        (pop1),
        .we         (we1),
        .write_addr (wa1),
        .read_addr  (ra1),
        .full       (full1),
        .empty      (empty1),
        .count      (cnt1),
        .overflow   (ovf1),
        .underflow  (unf1)
    );

    typedef struct {
        logic       we, full, empty, ovf, unf;
        logic [2:0] wa, ra, cnt;
    } snap_t;

    int          errors = 0;
    int          checks = 0;
    int          depth[2];
    int unsigned wcnt[2], rcnt[2];
    bit          eovf[2], eunf[2];
    logic [7:0]  ram[2][8];
    logic [7:0]  q0[$], q1[$];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic snap_t snap(int d);
        snap_t s;
        if (d == 0) begin
            s.we = we0; s.full = full0; s.empty = empty0;
            s.ovf = ovf0; s.unf = unf0;
            s.wa = {1'b0, wa0}; s.ra = {1'b0, ra0}; s.cnt = cnt0;
        end else begin
            s.we = we1; s.full = full1; s.empty = empty1;
            s.ovf = ovf1; s.unf = unf1;
            s.wa = wa1; s.ra = ra1; s.cnt = cnt1;
        end
        return s;
    endfunction

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] qfront(int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qop(int d, bit do_pop, bit do_push, logic [7:0] v);
        if (d == 0) begin
            if (do_pop) void'(q0.pop_front());
            if (do_push) q0.push_back(v);
        end else begin
            if (do_pop) void'(q1.pop_front());
            if (do_push) q1.push_back(v);
        end
    endtask

    task automatic check_state(int d);
        snap_t s;
        int    n;
        s = snap(d);
        n = qsize(d);
        chk($sformatf("count%0d", d), 32'(s.cnt), 32'(n));
        chk($sformatf("empty%0d", d), 32'(s.empty), 32'(n == 0));
        chk($sformatf("full%0d", d), 32'(s.full), 32'(n == depth[d]));
        chk($sformatf("waddr%0d", d), 32'(s.wa), wcnt[d] % depth[d]);
        chk($sformatf("raddr%0d", d), 32'(s.ra), rcnt[d] % depth[d]);
        chk($sformatf("ovf%0d", d), 32'(s.ovf), 32'(eovf[d]));
        chk($sformatf("unf%0d", d), 32'(s.unf), 32'(eunf[d]));
    endtask

    // Called at posedge+1; applies one cycle of requests.
    task automatic cyc(int d, bit pu, bit po, logic [7:0] data);
        snap_t s;
        int    n;
        bit    pop_ok, push_ok;
        if (d == 0) begin push0 = pu; pop0 = po; end
        else begin push1 = pu; pop1 = po; end
        #1;
        s = snap(d);
        n = qsize(d);
        pop_ok  = po && (n > 0);
        push_ok = pu && ((n < depth[d]) || pop_ok);
        chk($sformatf("we%0d", d), 32'(s.we), 32'(push_ok));
        if (pop_ok)
            chk($sformatf("rdata%0d", d), 32'(ram[d][s.ra]), 32'(qfront(d)));
        if (s.we === 1'b1) ram[d][s.wa] = data;
        qop(d, pop_ok, push_ok, data);
        wcnt[d] += 32'(push_ok);
        rcnt[d] += 32'(pop_ok);
        eovf[d] = pu && !push_ok;
        eunf[d] = po && !pop_ok;
        @(posedge clk);
        #1;
        push0 = 1'b0; pop0 = 1'b0; push1 = 1'b0; pop1 = 1'b0;
        check_state(d);
    endtask

    // Asserted between edges so the async path is what is observed.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            wcnt[d] = 0; rcnt[d] = 0; eovf[d] = 1'b0; eunf[d] = 1'b0;
        end
        check_state(0);
        check_state(1);
        chk("we_rst", {30'd0, we1, we0}, 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        depth[0] = 4;
        depth[1] = 5;
        rst_n = 1'b0;
        push0 = 1'b0; pop0 = 1'b0; push1 = 1'b0; pop1 = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        for (int i = 0; i < 4; i++) cyc(0, 1'b1, 1'b0, 8'(8'h10 + i));
        cyc(0, 1'b1, 1'b0, 8'hEE);
        cyc(0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(0, 1'b0, 1'b1, 8'h00);

        do_reset();
        cyc(0, 1'b0, 1'b1, 8'h00);
        cyc(0, 1'b1, 1'b1, 8'h55);
        cyc(0, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 3; i++) cyc(0, 1'b1, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 6; i++) cyc(0, 1'b1, 1'b1, 8'(8'hA0 + i));
        for (int i = 0; i < 4; i++) cyc(0, 1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 12; i++) begin
            cyc(1, 1'b1, 1'b0, 8'(8'h40 + i));
            cyc(1, 1'b0, 1'b1, 8'h00);
        end

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 200; i++) begin
                cyc(d, 1'($urandom_range(0, 99) < 55),
                    1'($urandom_range(0, 99) < 45), 8'($urandom));
            end
        end

        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 3; i++) cyc(1, 1'b1, 1'b0, 8'(8'h38 + i));
        do_reset();
        cyc(0, 1'b1, 1'b0, 8'h77);
        cyc(0, 1'b0, 1'b1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
